// File: rtl/pipeline_hold_scheduler_if.sv
// Handshake, hold and error-reporting bundle between the adder pipeline
// environment (master) and the hold scheduler (slave).
interface pipeline_hold_scheduler_if #(
  parameter int LAYERS = 7,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              out_ready;
  logic              out_valid;
  logic [LAYERS-1:0] error_signals;
  logic [LAYERS-1:0] hold_signals;
  logic              alarm;
  logic              locked;
  logic [4:0]        err_layer;
  logic [CNT_W-1:0]  err_count;
  logic [CNT_W-1:0]  drop_count;

  modport master (
    output in_valid, out_ready, error_signals,
    input  in_ready, out_valid, hold_signals, alarm, locked,
           err_layer, err_count, drop_count
  );

  modport slave (
    input  in_valid, out_ready, error_signals,
    output in_ready, out_valid, hold_signals, alarm, locked,
           err_layer, err_count, drop_count
  );
endinterface

// File: rtl/pipeline_hold_scheduler.sv
// Hold-signal sequencer for an N-layer parity-protected adder pipeline:
// ready/valid backpressure, token tracking, error drop/drain and lockout.
module pipeline_hold_scheduler #(
  parameter int LAYERS  = 7,
  parameter int MAX_ERR = 3,
  parameter int CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  pipeline_hold_scheduler_if.slave bus
);

  typedef enum logic [1:0] {RUN, STALL, DRAIN, LOCKED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state, state_next;
  logic [LAYERS-1:0]  valid, valid_next;
  logic [LAYERS-1:0]  adv;
  logic [LAYERS-1:0]  flagged;
  logic               active;
  logic               err_event;
  logic [5:0]         flag_num;
  logic [4:0]         flag_low;
  logic [CNT_W:0]     err_inc;
  logic [CNT_W+6:0]   drop_sum;

  logic               alarm;
  logic [4:0]         err_layer;
  logic [CNT_W-1:0]   err_count;
  logic [CNT_W-1:0]   drop_count;

  // A layer advances if any layer at or above it has a hole, or the sink takes.
  always_comb begin
    logic room;
    room = bus.out_ready;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      room   = room | ~valid[i];
      adv[i] = room;
    end
  end

  always_comb begin
    flagged   = bus.error_signals & valid;
    active    = (state == RUN) || (state == DRAIN);
    err_event = active && (|flagged);
    flag_num  = '0;
    flag_low  = '0;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (flagged[i]) begin
        flag_num = flag_num + 6'd1;
        flag_low = 5'(i);
      end
    end
    err_inc  = {1'b0, err_count} + {{CNT_W{1'b0}}, 1'b1};
    drop_sum = {7'd0, drop_count} + {{(CNT_W + 1){1'b0}}, flag_num};
  end

  // Next-state and token movement.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a default
    // first, so no path leaves a variable unassigned and no latch is inferred.
    state_next = state;
    valid_next = valid;
    if (err_event) begin
      valid_next = valid & ~flagged;
      state_next = (int'(err_inc) >= MAX_ERR) ? LOCKED : STALL;
    end else begin
      unique case (state)
        RUN, DRAIN: begin
          if (adv[0]) valid_next[0] = (state == RUN) && bus.in_valid;
          for (int i = 1; i < LAYERS; i++) begin
            if (adv[i]) valid_next[i] = valid[i-1];
          end
          if (state == DRAIN && valid == '0) state_next = RUN;
        end
        STALL:   state_next = DRAIN;
        LOCKED:  state_next = LOCKED;
        default: state_next = RUN;
      endcase
    end
  end

  // Handshake outputs. Gated by rst so holds are asserted the moment reset rises.
  always_comb begin
    bus.hold_signals = '1;
    bus.in_ready     = 1'b0;
    bus.out_valid    = 1'b0;
    if (!rst && !err_event && active) begin
      bus.hold_signals = ~adv;
      bus.in_ready     = (state == RUN) && adv[0];
      bus.out_valid    = valid[LAYERS-1];
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      valid      <= '0;
      alarm      <= 1'b0;
      err_layer  <= '0;
      err_count  <= '0;
      drop_count <= '0;
    end else begin
      state <= state_next;
      valid <= valid_next;
      alarm <= err_event;
      if (err_event) begin
        err_layer <= flag_low;
        if (err_count != CNT_MAX) err_count <= err_inc[CNT_W-1:0];
        drop_count <= (drop_sum > {7'd0, CNT_MAX}) ? CNT_MAX : drop_sum[CNT_W-1:0];
      end
    end
  end

  assign bus.alarm      = alarm;
  assign bus.locked     = (state == LOCKED);
  assign bus.err_layer  = err_layer;
  assign bus.err_count  = err_count;
  assign bus.drop_count = drop_count;

endmodule

// File: tb/tb_pipeline_hold_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic/errors compared
// cycle by cycle against a token-array reference model of the scheduler.
module tb_pipeline_hold_scheduler;
  localparam int L       = 7;
  localparam int MAX_ERR = 3;
  localparam int CNT_W   = 8;
  localparam int CMAX    = (1 << CNT_W) - 1;

  localparam int M_RUN    = 0;
  localparam int M_STALL  = 1;
  localparam int M_DRAIN  = 2;
  localparam int M_LOCKED = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipeline_hold_scheduler_if #(.LAYERS(L), .CNT_W(CNT_W)) bus ();

  pipeline_hold_scheduler #(.LAYERS(L), .MAX_ERR(MAX_ERR), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: token id per layer (0 = empty), mode, report registers.
  int tok[L];
  int mode;
  int next_id;
  int m_alarm;
  int m_err_layer;
  int m_errs;
  int m_drops;
  int m_del;
  int dut_del;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < L; i++) tok[i] = 0;
    mode        = M_RUN;
    m_alarm     = 0;
    m_err_layer = 0;
    m_errs      = 0;
    m_drops     = 0;
  endtask

  // Layer i can move when a hole exists at or above it, or the sink accepts.
  task automatic model_adv(input logic ordy, output logic [L-1:0] a);
    for (int i = 0; i < L; i++) begin
      a[i] = ordy;
      for (int j = i; j < L; j++) if (tok[j] == 0) a[i] = 1'b1;
    end
  endtask

  task automatic model_live(output logic [L-1:0] live);
    for (int i = 0; i < L; i++) live[i] = (tok[i] != 0);
  endtask

  task automatic check_outputs();
    logic [L-1:0] a, live, eh;
    logic ei, eo, ev, flowing;
    model_adv(bus.out_ready, a);
    model_live(live);
    flowing = (mode == M_RUN) || (mode == M_DRAIN);
    ev = flowing && ((bus.error_signals & live) != '0);
    eh = '1; ei = 1'b0; eo = 1'b0;
    if (!rst && !ev && flowing) begin
      eh = ~a;
      eo = live[L-1];
      ei = (mode == M_RUN) && a[0];
    end
    check("hold",       32'(bus.hold_signals), 32'(eh));
    check("in_ready",   32'(bus.in_ready),     32'(ei));
    check("out_valid",  32'(bus.out_valid),    32'(eo));
    check("alarm",      32'(bus.alarm),        32'(m_alarm));
    check("locked",     32'(bus.locked),       32'(mode == M_LOCKED));
    check("err_layer",  32'(bus.err_layer),    32'(m_err_layer));
    check("err_count",  32'(bus.err_count),    32'((m_errs > CMAX) ? CMAX : m_errs));
    check("drop_count", 32'(bus.drop_count),   32'((m_drops > CMAX) ? CMAX : m_drops));
  endtask

  task automatic model_next(input logic iv, input logic ordy, input logic [L-1:0] err);
    int old[L];
    int cnt, low, m0;
    logic [L-1:0] a, live;
    logic ev;
    if (rst) return;
    old = tok;
    m0  = mode;
    model_adv(ordy, a);
    model_live(live);
    ev = (m0 == M_RUN || m0 == M_DRAIN) && ((err & live) != '0);
    if (ev) begin
      cnt = 0; low = -1;
      for (int i = 0; i < L; i++) begin
        if (live[i] && err[i]) begin
          tok[i] = 0;
          cnt++;
          if (low < 0) low = i;
        end
      end
      m_errs++;
      m_drops    += cnt;
      m_err_layer = low;
      m_alarm     = 1;
      mode        = (m_errs >= MAX_ERR) ? M_LOCKED : M_STALL;
    end else begin
      m_alarm = 0;
      if (m0 == M_RUN || m0 == M_DRAIN) begin
        if (live[L-1] && ordy) m_del++;
        for (int i = 0; i < L; i++) begin
          if (a[i]) begin
            if (i == 0) begin
              if (m0 == M_RUN && iv) begin
                tok[0] = next_id;
                next_id++;
              end else begin
                tok[0] = 0;
              end
            end else begin
              tok[i] = old[i-1];
            end
          end
        end
        if (m0 == M_DRAIN && live == '0) mode = M_RUN;
      end else if (m0 == M_STALL) begin
        mode = M_DRAIN;
      end
    end
  endtask

  task automatic step(input logic iv, input logic ordy, input logic [L-1:0] err);
    @(negedge clk);
    bus.in_valid      = iv;
    bus.out_ready     = ordy;
    bus.error_signals = err;
    #1;
    cyc++;
    check_outputs();
    if (bus.out_valid && bus.out_ready) dut_del++;
    model_next(iv, ordy, err);
  endtask

  // Asynchronous reset raised between clock edges; idle inputs before release.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    repeat (2) begin
      @(negedge clk);
      #1;
      check_outputs();
    end
    bus.in_valid      = 1'b0;
    bus.out_ready     = 1'b1;
    bus.error_signals = '0;
    rst = 1'b0;
  endtask

  initial begin
    int first_acc, first_ov, locked_cycles;
    logic mid_reset_done;
    logic [L-1:0] err;
    next_id = 1;
    m_del   = 0;
    dut_del = 0;
    bus.in_valid      = 1'b0;
    bus.out_ready     = 1'b1;
    bus.error_signals = '0;
    model_reset();
    #2;
    do_reset();

    // Full throughput and first-word latency.
    first_acc = -1;
    first_ov  = -1;
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 1'b1, '0);
      if (first_acc < 0 && bus.in_ready) first_acc = cyc;
      if (first_ov < 0 && bus.out_valid) first_ov = cyc;
    end
    check("latency", 32'(first_ov - first_acc), 32'd7);

    // Backpressure with a full pipe, then release.
    repeat (10) step(1'b1, 1'b0, '0);
    check("hold_full", 32'(bus.hold_signals), 32'h7F);
    repeat (12) step(1'($urandom_range(0, 1)), 1'b1, '0);

    // Error on layer 3 with a full pipe, then drain.
    repeat (10) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 7'h08);
    repeat (14) step(1'b0, 1'b1, '0);

    // Two-layer error event.
    repeat (10) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 7'h41);
    repeat (14) step(1'b1, 1'b1, '0);

    // Third event locks the controller.
    repeat (10) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 7'h04);
    repeat (6) step(1'b1, 1'b1, '0);
    check("lock_hold", 32'(bus.hold_signals), 32'h7F);
    @(negedge clk);
    do_reset();

    // Errors on empty layers are ignored.
    step(1'b0, 1'b1, 7'h7F);
    step(1'b0, 1'b1, 7'h7F);

    // Reset asserted in the middle of a drain.
    repeat (10) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 7'h10);
    repeat (3) step(1'b0, 1'b1, '0);
    #2;
    do_reset();

    // Randomized traffic, backpressure and error injection.
    locked_cycles  = 0;
    mid_reset_done = 1'b0;
    for (int c = 0; c < 900; c++) begin
      err = ($urandom_range(0, 24) == 0) ? L'($urandom) : '0;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, err);
      locked_cycles = (mode == M_LOCKED) ? locked_cycles + 1 : 0;
      if (locked_cycles > 4) begin
        locked_cycles = 0;
        #2;
        do_reset();
      end else if (mode == M_DRAIN && !mid_reset_done && $urandom_range(0, 3) == 0) begin
        mid_reset_done = 1'b1;
        #2;
        do_reset();
      end
    end

    check("delivered", 32'(dut_del), 32'(m_del));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
